fifo_rd_stream: RTL and testbench

Read-side drainer for the team's asynchronous FIFO. Runs entirely in the FIFO read clock domain. Drives `rd_en`, captures the registered `rd_data`, and presents words on a valid/ready master stream with a `m_last` marker every `PKT_LEN` beats. It sustains one word per cycle while the FIFO is non-empty and the sink is ready, and never over-reads the FIFO.

---
 rtl/async_fifo_pkg.sv | 19 +
 rtl/fifo_rd_stream_if.sv | 28 ++
 rtl/stream_buf2.sv | 58 +++++
 rtl/fifo_rd_stream.sv | 69 ++++++
 tb/tb_fifo_rd_stream.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO and its read-side drainer, so both
// sides agree on word width and the drainer's buffer occupancy encoding.
package async_fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // Beat counter width; a 1-beat packet still needs a 1-bit counter.
  function automatic int beat_cnt_w(input int pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of the drainer.
// The master side is the drainer; the slave side is FIFO + sink.
interface fifo_rd_stream_if
  import async_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
);

  logic             empty;
  logic [WIDTH-1:0] rd_data;
  logic             rd_en;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [15:0]      pkt_count;

  modport master (
    input  empty, rd_data, m_ready,
    output rd_en, m_valid, m_data, m_last, pkt_count
  );

  modport slave (
    output empty, rd_data, m_ready,
    input  rd_en, m_valid, m_data, m_last, pkt_count
  );

endinterface

// File: rtl/stream_buf2.sv
// Two-entry output buffer; head is the word currently offered downstream.
// A push lands at the first free slot after any same-cycle pop.
module stream_buf2
  import async_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             rd_clk,
  input  logic             r_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output occ_t             occ
);

  logic [WIDTH-1:0] tail;

  always_ff @(posedge rd_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      occ  <= OCC_EMPTY;
      head <= '0;
      tail <= '0;
    end else begin
      case (occ)
        OCC_EMPTY: begin
          if (push) begin
            head <= push_data;
            occ  <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            tail <= push_data;
            occ  <= OCC_TWO;
          end else if (pop) begin
            occ <= OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          // Pop shifts tail forward; a simultaneous push refills the tail.
          if (pop) begin
            head <= tail;
            if (push) tail <= push_data;
            else      occ  <= OCC_ONE;
          end
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  overflow_a: assert property (@(posedge rd_clk) disable iff (!r_rst_n)
    !(push && !pop && occ == OCC_TWO));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drainer: pulls words from the async FIFO into a 2-entry buffer
// and presents them as a packetized valid/ready stream.
module fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int WIDTH   = FIFO_WIDTH,
  parameter int PKT_LEN = 4
) (
  input  logic             rd_clk,
  input  logic             r_rst_n,
  fifo_rd_stream_if.master bus
);

  localparam int            BW        = beat_cnt_w(PKT_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  occ_t             occ;
  logic [WIDTH-1:0] head;
  logic             inflight;
  logic             m_valid_i;
  logic             m_last_i;
  logic             pop;
  logic             rd_en_i;
  logic [2:0]       pending;
  logic [BW-1:0]    beat_cnt;
  logic [15:0]      pkt_count;

  assign m_valid_i = (occ != OCC_EMPTY);
  assign pop       = m_valid_i && bus.m_ready;

  // Words that will occupy the buffer after this edge; one more read may
  // issue only if a slot is still guaranteed when its data returns.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign rd_en_i = r_rst_n && !bus.empty && (pending <= 3'd1);

  assign m_last_i = m_valid_i && (beat_cnt == LAST_BEAT);

  always_ff @(posedge rd_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      inflight  <= 1'b0;
      beat_cnt  <= '0;
      pkt_count <= '0;
    end else begin
      inflight <= rd_en_i;
      if (pop) begin
        if (beat_cnt == LAST_BEAT) beat_cnt <= '0;
        else                       beat_cnt <= beat_cnt + 1'b1;
        if (m_last_i) pkt_count <= pkt_count + 16'd1;
      end
    end
  end

  stream_buf2 #(.WIDTH(WIDTH)) u_buf (
    .rd_clk    (rd_clk),
    .r_rst_n   (r_rst_n),
    .push      (inflight),
    .push_data (bus.rd_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  assign bus.rd_en     = rd_en_i;
  assign bus.m_valid   = m_valid_i;
  assign bus.m_data    = head;
  assign bus.m_last    = m_last_i;
  assign bus.pkt_count = pkt_count;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural FIFO read port, stream monitor and
// directed scenarios for PKT_LEN=4 and PKT_LEN=1.
`timescale 1ns/1ps
module tb_fifo_rd_stream;

  logic rd_clk  = 1'b0;
  logic r_rst_n = 1'b0;
  logic m_ready_drv = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 rd_clk = ~rd_clk;
  always @(posedge rd_clk) cyc <= cyc + 1;

  fifo_rd_stream_if #(.WIDTH(8)) bus ();
  fifo_rd_stream_if #(.WIDTH(8)) bus1 ();

  fifo_rd_stream #(.WIDTH(8), .PKT_LEN(4)) dut (
    .rd_clk (rd_clk), .r_rst_n (r_rst_n), .bus (bus));
  fifo_rd_stream #(.WIDTH(8), .PKT_LEN(1)) dut1 (
    .rd_clk (rd_clk), .r_rst_n (r_rst_n), .bus (bus1));

  // FIFO models: combinational empty, registered rd_data, flushed by reset
  logic [7:0] mem  [0:255];
  logic [7:0] mem1 [0:255];
  int wr_ptr = 0, rd_ptr = 0, wr1 = 0, rd1 = 0;
  logic [7:0] rdq = '0, rdq1 = '0;

  assign bus.empty    = (wr_ptr == rd_ptr);
  assign bus.rd_data  = rdq;
  assign bus.m_ready  = m_ready_drv;
  assign bus1.empty   = (wr1 == rd1);
  assign bus1.rd_data = rdq1;
  assign bus1.m_ready = 1'b1;

  always @(posedge rd_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rd_ptr <= wr_ptr; rdq <= '0;
      rd1 <= wr1; rdq1 <= '0;
    end else begin
      if (bus.rd_en && !bus.empty) begin
        rdq <= mem[rd_ptr]; rd_ptr <= rd_ptr + 1;
      end
      if (bus1.rd_en && !bus1.empty) begin
        rdq1 <= mem1[rd1]; rd1 <= rd1 + 1;
      end
    end
  end

  // Stream monitor, sampled mid-cycle
  logic [7:0] beat_data [0:255];
  logic       beat_last [0:255];
  int         beat_cyc  [0:255];
  int         rd_cyc    [0:255];
  logic [7:0] beat1_data [0:15];
  logic       beat1_last [0:15];
  int beat_n = 0, rd_n = 0, beat1_n = 0, outst = 0, mon_viol = 0;

  always @(negedge rd_clk) begin : mon
    int v;
    int acc, pp;
    v = 0;
    acc = int'(bus.rd_en && !bus.empty);
    pp  = int'(bus.m_valid && bus.m_ready);
    if (!r_rst_n) begin
      outst <= 0;
      if (bus.rd_en || bus1.rd_en) begin
        v++;
        $display("FAIL rd_en_in_reset: rd_en=%0b/%0b required 0", bus.rd_en, bus1.rd_en);
      end
    end else begin
      if (bus.rd_en && bus.empty) begin
        v++;
        $display("FAIL rd_en_while_empty: rd_en=1 with empty=1 at cycle %0d", cyc);
      end
      if (bus1.rd_en && bus1.empty) begin
        v++;
        $display("FAIL rd_en_while_empty_pl1: rd_en=1 with empty=1 at cycle %0d", cyc);
      end
      if (outst + acc - pp > 2) begin
        v++;
        $display("FAIL occupancy: %0d words outstanding, required <= 2", outst + acc - pp);
      end
      outst <= outst + acc - pp;
      if (pp != 0) begin
        beat_data[beat_n] <= bus.m_data;
        beat_last[beat_n] <= bus.m_last;
        beat_cyc[beat_n]  <= cyc;
        beat_n <= beat_n + 1;
      end
      if (acc != 0) begin
        rd_cyc[rd_n] <= cyc;
        rd_n <= rd_n + 1;
      end
      if (bus1.m_valid && bus1.m_ready) begin
        beat1_data[beat1_n] <= bus1.m_data;
        beat1_last[beat1_n] <= bus1.m_last;
        beat1_n <= beat1_n + 1;
      end
    end
    mon_viol <= mon_viol + v;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge rd_clk); #1; end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr] = d; wr_ptr = wr_ptr + 1;
  endtask

  task automatic push1(input logic [7:0] d);
    mem1[wr1] = d; wr1 = wr1 + 1;
  endtask

  task automatic wait_beats(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (beat_n >= target) begin ok = 1'b1; break; end
      tick(1);
    end
    if (beat_n >= target) ok = 1'b1;
  endtask

  task automatic do_reset();
    tick(1);
    r_rst_n = 1'b0; m_ready_drv = 1'b0;
    tick(3);
    r_rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    tick(2);
    push(8'hEE);
    #1;
    n_assert++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
    n_assert++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    n_assert++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL reset_m_data: got %h want 00", bus.m_data); end
    n_assert++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
    n_assert++; if (bus.pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count: got %0d want 0", bus.pkt_count); end
    tick(2);
    r_rst_n = 1'b1;
    tick(2);
    n_assert++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flush_valid: got %b want 0", bus.m_valid); end
  endtask

  task automatic test_streaming();
    int b0, r0; bit ok;
    do_reset();
    m_ready_drv = 1'b1;
    b0 = beat_n; r0 = rd_n;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    wait_beats(b0 + 8, 40, ok);
    tick(3);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stream_timeout: got %0d beats want 8", beat_n - b0); end
    for (int i = 0; i < 8; i++) begin
      n_assert++; if (beat_data[b0+i] !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, beat_data[b0+i], 8'h10 + 8'(i)); end
      n_assert++; if (beat_last[b0+i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL stream_last[%0d]: got %b want %b", i, beat_last[b0+i], (i % 4 == 3)); end
    end
    n_assert++; if (beat_cyc[b0] - rd_cyc[r0] !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d want 2", beat_cyc[b0] - rd_cyc[r0]); end
    n_assert++; if (beat_cyc[b0+7] - beat_cyc[b0] !== 7) begin n_fail++; $display("FAIL stream_throughput: got %0d cycles want 7", beat_cyc[b0+7] - beat_cyc[b0]); end
    n_assert++; if (rd_n - r0 !== 8) begin n_fail++; $display("FAIL stream_reads: got %0d want 8", rd_n - r0); end
    n_assert++; if (bus.pkt_count !== 16'd2) begin n_fail++; $display("FAIL stream_pkt_count: got %0d want 2", bus.pkt_count); end
    n_assert++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle_valid: got %b want 0", bus.m_valid); end
  endtask

  task automatic test_backpressure();
    int b0, r0; bit ok;
    do_reset();
    b0 = beat_n; r0 = rd_n;
    for (int i = 0; i < 6; i++) push(8'hA0 + 8'(i));
    tick(10);
    n_assert++; if (rd_n - r0 !== 2) begin n_fail++; $display("FAIL bp_reads_held: got %0d want 2", rd_n - r0); end
    n_assert++; if (bus.m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held: got %b want 1", bus.m_valid); end
    n_assert++; if (bus.m_data !== 8'hA0) begin n_fail++; $display("FAIL bp_data_held: got %h want a0", bus.m_data); end
    n_assert++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en_held: got %b want 0", bus.rd_en); end
    m_ready_drv = 1'b1;
    wait_beats(b0 + 6, 40, ok);
    tick(3);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_timeout: got %0d beats want 6", beat_n - b0); end
    for (int i = 0; i < 6; i++) begin
      n_assert++; if (beat_data[b0+i] !== 8'hA0 + 8'(i)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, beat_data[b0+i], 8'hA0 + 8'(i)); end
      n_assert++; if (beat_last[b0+i] !== (i == 3)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b want %b", i, beat_last[b0+i], (i == 3)); end
    end
    n_assert++; if (beat_cyc[b0+5] - beat_cyc[b0] !== 5) begin n_fail++; $display("FAIL bp_no_gaps: got %0d cycles want 5", beat_cyc[b0+5] - beat_cyc[b0]); end
    n_assert++; if (rd_cyc[r0+2] !== beat_cyc[b0]) begin n_fail++; $display("FAIL bp_resume_read: read at %0d want %0d", rd_cyc[r0+2], beat_cyc[b0]); end
    n_assert++; if (rd_n - r0 !== 6) begin n_fail++; $display("FAIL bp_reads_total: got %0d want 6", rd_n - r0); end
    n_assert++; if (bus.pkt_count !== 16'd1) begin n_fail++; $display("FAIL bp_pkt_count: got %0d want 1", bus.pkt_count); end
  endtask

  task automatic test_empty_mid();
    int b0, r0; bit ok;
    do_reset();
    m_ready_drv = 1'b1;
    b0 = beat_n; r0 = rd_n;
    push(8'h01); push(8'h02);
    tick(8);
    n_assert++; if (beat_n - b0 !== 2) begin n_fail++; $display("FAIL em_beats: got %0d want 2", beat_n - b0); end
    n_assert++; if (beat_data[b0] !== 8'h01 || beat_data[b0+1] !== 8'h02) begin n_fail++; $display("FAIL em_data: got %h %h want 01 02", beat_data[b0], beat_data[b0+1]); end
    n_assert++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL em_valid_low: got %b want 0", bus.m_valid); end
    n_assert++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL em_rd_en_low: got %b want 0", bus.rd_en); end
    n_assert++; if (rd_n - r0 !== 2) begin n_fail++; $display("FAIL em_reads: got %0d want 2", rd_n - r0); end
    push(8'h03); push(8'h04);
    wait_beats(b0 + 4, 30, ok);
    tick(3);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL em_timeout: got %0d beats want 4", beat_n - b0); end
    n_assert++; if (beat_data[b0+2] !== 8'h03 || beat_data[b0+3] !== 8'h04) begin n_fail++; $display("FAIL em_late_data: got %h %h want 03 04", beat_data[b0+2], beat_data[b0+3]); end
    for (int i = 0; i < 4; i++) begin
      n_assert++; if (beat_last[b0+i] !== (i == 3)) begin n_fail++; $display("FAIL em_last[%0d]: got %b want %b", i, beat_last[b0+i], (i == 3)); end
    end
    n_assert++; if (bus.pkt_count !== 16'd1) begin n_fail++; $display("FAIL em_pkt_count: got %0d want 1", bus.pkt_count); end
  endtask

  task automatic test_random_ready();
    int b0, r0, v0; bit ok;
    logic [7:0] exp_d [64];
    do_reset();
    b0 = beat_n; r0 = rd_n; v0 = mon_viol;
    for (int i = 0; i < 64; i++) begin
      exp_d[i] = 8'(i * 37 + 5);
      push(exp_d[i]);
    end
    for (int i = 0; i < 1000; i++) begin
      if (beat_n >= b0 + 64) break;
      m_ready_drv = 1'($urandom_range(0, 1));
      tick(1);
    end
    m_ready_drv = 1'b1;
    wait_beats(b0 + 64, 20, ok);
    tick(3);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rnd_timeout: got %0d beats want 64", beat_n - b0); end
    for (int i = 0; i < 64; i++) begin
      n_assert++; if (beat_data[b0+i] !== exp_d[i]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h want %h", i, beat_data[b0+i], exp_d[i]); end
      n_assert++; if (beat_last[b0+i] !== (i % 4 == 3)) begin n_fail++; $display("FAIL rnd_last[%0d]: got %b want %b", i, beat_last[b0+i], (i % 4 == 3)); end
    end
    n_assert++; if (rd_n - r0 !== 64) begin n_fail++; $display("FAIL rnd_reads: got %0d want 64", rd_n - r0); end
    n_assert++; if (bus.pkt_count !== 16'd16) begin n_fail++; $display("FAIL rnd_pkt_count: got %0d want 16", bus.pkt_count); end
    n_assert++; if (mon_viol - v0 !== 0) begin n_fail++; $display("FAIL rnd_protocol: got %0d violations want 0", mon_viol - v0); end
  endtask

  task automatic test_pkt_len1();
    int b0;
    do_reset();
    b0 = beat1_n;
    push1(8'h31); push1(8'h32); push1(8'h33);
    for (int i = 0; i < 30; i++) begin
      if (beat1_n >= b0 + 3) break;
      tick(1);
    end
    tick(3);
    n_assert++; if (beat1_n - b0 !== 3) begin n_fail++; $display("FAIL pl1_beats: got %0d want 3", beat1_n - b0); end
    for (int i = 0; i < 3; i++) begin
      n_assert++; if (beat1_data[b0+i] !== 8'h31 + 8'(i)) begin n_fail++; $display("FAIL pl1_data[%0d]: got %h want %h", i, beat1_data[b0+i], 8'h31 + 8'(i)); end
      n_assert++; if (beat1_last[b0+i] !== 1'b1) begin n_fail++; $display("FAIL pl1_last[%0d]: got %b want 1", i, beat1_last[b0+i]); end
    end
    n_assert++; if (bus1.pkt_count !== 16'd3) begin n_fail++; $display("FAIL pl1_pkt_count: got %0d want 3", bus1.pkt_count); end
  endtask

  task automatic test_reset_mid();
    int b0, b1; bit ok;
    do_reset();
    m_ready_drv = 1'b1;
    b0 = beat_n;
    for (int i = 0; i < 12; i++) push(8'h50 + 8'(i));
    wait_beats(b0 + 6, 40, ok);
    n_assert++; if (ok !== 1'b1 || bus.pkt_count !== 16'd1) begin n_fail++; $display("FAIL rm_pre: beats %0d pkt %0d want 6 and 1", beat_n - b0, bus.pkt_count); end
    r_rst_n = 1'b0;
    #1;
    n_assert++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid: got %b want 0", bus.m_valid); end
    n_assert++; if (bus.m_data !== 8'h00) begin n_fail++; $display("FAIL rm_data: got %h want 00", bus.m_data); end
    n_assert++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL rm_last: got %b want 0", bus.m_last); end
    n_assert++; if (bus.pkt_count !== 16'd0) begin n_fail++; $display("FAIL rm_pkt_count: got %0d want 0", bus.pkt_count); end
    n_assert++; if (bus.rd_en !== 1'b0) begin n_fail++; $display("FAIL rm_rd_en: got %b want 0", bus.rd_en); end
    tick(3);
    r_rst_n = 1'b1;
    tick(2);
    b1 = beat_n;
    n_assert++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL rm_discard: got m_valid %b want 0", bus.m_valid); end
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    wait_beats(b1 + 4, 30, ok);
    tick(3);
    n_assert++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rm_timeout: got %0d beats want 4", beat_n - b1); end
    for (int i = 0; i < 4; i++) begin
      n_assert++; if (beat_data[b1+i] !== 8'h60 + 8'(i)) begin n_fail++; $display("FAIL rm_data[%0d]: got %h want %h", i, beat_data[b1+i], 8'h60 + 8'(i)); end
      n_assert++; if (beat_last[b1+i] !== (i == 3)) begin n_fail++; $display("FAIL rm_last[%0d]: got %b want %b", i, beat_last[b1+i], (i == 3)); end
    end
    n_assert++; if (bus.pkt_count !== 16'd1) begin n_fail++; $display("FAIL rm_pkt_after: got %0d want 1", bus.pkt_count); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_mid();
    test_random_ready();
    test_pkt_len1();
    test_reset_mid();
    n_assert++; if (mon_viol !== 0) begin n_fail++; $display("FAIL protocol_total: got %0d violations want 0", mon_viol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
